craps_game: RTL and testbench

Game-control stage downstream of the die roller. It consumes the roller's 3-bit face value and its `choose` strobe, pairs two successive picks into one throw, and plays the pass-line rules of craps: natural, craps, point, then win or seven-out. It drives the roller's `enable` and presents dice, sum, point, throw count and the win/lose result to the display stage.

---
 rtl/craps_pkg.sv | 30 +++
 rtl/roll_capture.sv | 43 ++++
 rtl/craps_game.sv | 144 ++++++++++++++
 tb/tb_craps_game.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/craps_pkg.sv
// craps_pkg: shared types and fixed constants for the craps game controller.
//   state_t        : game FSM state encoding
//   SUM_* constants: natural / craps sums used on the come-out throw
//   THROWS_MAX     : saturation value of the per-game throw counter
//   is_roll_state  : true in the states that wait for a die pick
package craps_pkg;

  typedef enum logic [2:0] {
    FIRST_A,
    FIRST_B,
    EVAL_FIRST,
    POINT_A,
    POINT_B,
    EVAL_POINT,
    WIN,
    LOSE
  } state_t;

  localparam logic [3:0] SUM_NATURAL_7  = 4'd7;
  localparam logic [3:0] SUM_NATURAL_11 = 4'd11;
  localparam logic [3:0] SUM_CRAPS_2    = 4'd2;
  localparam logic [3:0] SUM_CRAPS_3    = 4'd3;
  localparam logic [3:0] SUM_CRAPS_12   = 4'd12;
  localparam logic [3:0] THROWS_MAX     = 4'd15;

  function automatic logic is_roll_state(input state_t s);
    return (s == FIRST_A) || (s == FIRST_B) || (s == POINT_A) || (s == POINT_B);
  endfunction

endpackage

// File: rtl/roll_capture.sv
// roll_capture: turns the roller's level-style choose strobe into exactly one
// pick pulse per button press/release.
//   clk, rst       : system clock, synchronous active-high reset
//   i_roll_en      : roller currently enabled (arming allowed)
//   i_roll_state   : FSM is in a state that accepts a pick
//   i_clr          : FSM is entering FIRST_A from a terminal state
//   i_choose       : roller strobe
//   i_num          : die face from the roller
//   o_pick         : one-cycle pulse, face in i_num is valid and must be taken
module roll_capture
  import craps_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       i_roll_en,
  input  logic       i_roll_state,
  input  logic       i_clr,
  input  logic       i_choose,
  input  logic [2:0] i_num,
  output logic       o_pick
);

  logic r_armed;
  logic w_attempt;
  logic w_face_ok;

  // An attempt consumes the arm even when the face is bad, so a glitchy face
  // needs a fresh release before the next pick is accepted.
  assign w_attempt = r_armed & i_choose & i_roll_state;
  assign w_face_ok = (i_num != 3'd0) && (i_num != 3'd7);
  assign o_pick    = w_attempt & w_face_ok;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_armed <= 1'b0;
    end else if (i_clr || w_attempt) begin
      r_armed <= 1'b0;
    end else if (i_roll_en && !i_choose) begin
      r_armed <= 1'b1;
    end
  end

endmodule

// File: rtl/craps_game.sv
// craps_game: pass-line craps controller downstream of the die roller.
// Pairs two picks into a throw, evaluates come-out and point throws, and
// reports dice, sum, point, throw count and the win/lose result.
//   clk, rst  : system clock, synchronous active-high reset
//   num       : die face 1..6 (0 and 7 are rejected)
//   choose    : roller strobe
//   new_game  : restart from WIN/LOSE
//   roll_en   : roller enable, low only in WIN/LOSE
//   die_a/b   : faces of the current throw
//   sum       : die_a + die_b
//   point     : established point, 0 if none
//   throws    : completed throws this game, saturating at 15
//   win/lose  : game result
//
// state      | meaning
// FIRST_A    | come-out throw, waiting for first die
// FIRST_B    | come-out throw, waiting for second die
// EVAL_FIRST | judge come-out sum: natural, craps or set point
// POINT_A    | point throw, waiting for first die
// POINT_B    | point throw, waiting for second die
// EVAL_POINT | judge point throw: make point, seven-out or keep rolling
// WIN        | game won, hold until new_game
// LOSE       | game lost, hold until new_game
module craps_game
  import craps_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] num,
  input  logic       choose,
  input  logic       new_game,
  output logic       roll_en,
  output logic [2:0] die_a,
  output logic [2:0] die_b,
  output logic [3:0] sum,
  output logic [3:0] point,
  output logic [3:0] throws,
  output logic       win,
  output logic       lose
);

  state_t     r_state;
  logic [2:0] r_die_a;
  logic [2:0] r_die_b;
  logic [3:0] r_sum;
  logic [3:0] r_point;
  logic [3:0] r_throws;
  logic       r_win;
  logic       r_lose;

  logic w_roll_en;
  logic w_restart;
  logic w_pick;

  assign w_roll_en = (r_state != WIN) && (r_state != LOSE);
  assign w_restart = !w_roll_en && new_game;

  roll_capture u_roll_capture (
    .clk         (clk),
    .rst         (rst),
    .i_roll_en   (w_roll_en),
    .i_roll_state(is_roll_state(r_state)),
    .i_clr       (w_restart),
    .i_choose    (choose),
    .i_num       (num),
    .o_pick      (w_pick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= FIRST_A;
      r_die_a  <= 3'd0;
      r_die_b  <= 3'd0;
      r_sum    <= 4'd0;
      r_point  <= 4'd0;
      r_throws <= 4'd0;
      r_win    <= 1'b0;
      r_lose   <= 1'b0;
    end else begin
      unique case (r_state)
        FIRST_A, POINT_A: begin
          if (w_pick) begin
            r_die_a <= num;
            r_state <= (r_state == FIRST_A) ? FIRST_B : POINT_B;
          end
        end
        FIRST_B, POINT_B: begin
          if (w_pick) begin
            r_die_b  <= num;
            r_sum    <= {1'b0, r_die_a} + {1'b0, num};
            r_throws <= (r_throws == THROWS_MAX) ? r_throws : r_throws + 4'd1;
            r_state  <= (r_state == FIRST_B) ? EVAL_FIRST : EVAL_POINT;
          end
        end
        EVAL_FIRST: begin
          if (r_sum == SUM_NATURAL_7 || r_sum == SUM_NATURAL_11) begin
            r_win   <= 1'b1;
            r_state <= WIN;
          end else if (r_sum == SUM_CRAPS_2 || r_sum == SUM_CRAPS_3 ||
                       r_sum == SUM_CRAPS_12) begin
            r_lose  <= 1'b1;
            r_state <= LOSE;
          end else begin
            r_point <= r_sum;
            r_state <= POINT_A;
          end
        end
        EVAL_POINT: begin
          if (r_sum == r_point) begin
            r_win   <= 1'b1;
            r_state <= WIN;
          end else if (r_sum == SUM_NATURAL_7) begin
            r_lose  <= 1'b1;
            r_state <= LOSE;
          end else begin
            r_state <= POINT_A;
          end
        end
        WIN, LOSE: begin
          if (new_game) begin
            r_die_a  <= 3'd0;
            r_die_b  <= 3'd0;
            r_sum    <= 4'd0;
            r_point  <= 4'd0;
            r_throws <= 4'd0;
            r_win    <= 1'b0;
            r_lose   <= 1'b0;
            r_state  <= FIRST_A;
          end
        end
      endcase
    end
  end

  assign roll_en = w_roll_en;
  assign die_a   = r_die_a;
  assign die_b   = r_die_b;
  assign sum     = r_sum;
  assign point   = r_point;
  assign throws  = r_throws;
  assign win     = r_win;
  assign lose    = r_lose;

endmodule

// File: tb/tb_craps_game.sv
// Testbench for craps_game: directed game scenarios with literal expectations
// followed by randomized play, all outputs compared every cycle against a
// behavioural game model.
module tb_craps_game;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] num = 3'd0;
  logic       choose = 1'b0;
  logic       new_game = 1'b0;
  logic       roll_en;
  logic [2:0] die_a;
  logic [2:0] die_b;
  logic [3:0] sum;
  logic [3:0] point;
  logic [3:0] throws;
  logic       win;
  logic       lose;

  int checks = 0;
  int errors = 0;

  craps_game dut (
    .clk     (clk),
    .rst     (rst),
    .num     (num),
    .choose  (choose),
    .new_game(new_game),
    .roll_en (roll_en),
    .die_a   (die_a),
    .die_b   (die_b),
    .sum     (sum),
    .point   (point),
    .throws  (throws),
    .win     (win),
    .lose    (lose)
  );

  always #5 clk = ~clk;

  // Behavioural game model
  int m_valid    = 0;
  int m_over     = 0;  // 0 playing, 1 won, 2 lost
  int m_eval     = 0;  // a completed throw awaits judgement
  int m_have_a   = 0;
  int m_released = 0;  // button released since the last pick attempt
  int m_a = 0, m_b = 0, m_sum = 0, m_point = 0, m_throws = 0;

  always @(posedge clk) begin
    if (rst) begin
      m_valid = 1; m_over = 0; m_eval = 0; m_have_a = 0; m_released = 0;
      m_a = 0; m_b = 0; m_sum = 0; m_point = 0; m_throws = 0;
    end else if (m_valid != 0) begin
      if (m_over != 0) begin
        if (new_game) begin
          m_over = 0; m_eval = 0; m_have_a = 0; m_released = 0;
          m_a = 0; m_b = 0; m_sum = 0; m_point = 0; m_throws = 0;
        end
      end else if (m_eval != 0) begin
        m_eval = 0;
        if (m_point == 0) begin
          if (m_sum == 7 || m_sum == 11) m_over = 1;
          else if (m_sum == 2 || m_sum == 3 || m_sum == 12) m_over = 2;
          else m_point = m_sum;
        end else begin
          if (m_sum == m_point) m_over = 1;
          else if (m_sum == 7) m_over = 2;
        end
        if (!choose) m_released = 1;
      end else if (m_released != 0 && choose) begin
        m_released = 0;
        if (num >= 1 && num <= 6) begin
          if (m_have_a == 0) begin
            m_a = int'(num);
            m_have_a = 1;
          end else begin
            m_b = int'(num);
            m_sum = m_a + m_b;
            m_throws = (m_throws >= 15) ? 15 : m_throws + 1;
            m_have_a = 0;
            m_eval = 1;
          end
        end
      end else if (!choose) begin
        m_released = 1;
      end
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (m_valid != 0) begin
      chk("roll_en", int'(roll_en), (m_over == 0) ? 1 : 0);
      chk("die_a",   int'(die_a),   m_a);
      chk("die_b",   int'(die_b),   m_b);
      chk("sum",     int'(sum),     m_sum);
      chk("point",   int'(point),   m_point);
      chk("throws",  int'(throws),  m_throws);
      chk("win",     int'(win),     (m_over == 1) ? 1 : 0);
      chk("lose",    int'(lose),    (m_over == 2) ? 1 : 0);
    end
  end

  // Release then press; returns at the negedge after the capture edge with
  // choose left high.
  task automatic pick(input int face);
    num = 3'(face);
    choose = 1'b0;
    @(negedge clk);
    choose = 1'b1;
    @(negedge clk);
  endtask

  task automatic pulse_new_game();
    new_game = 1'b1;
    @(negedge clk);
    new_game = 1'b0;
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("lit_reset_roll_en", int'(roll_en), 1);
    chk("lit_reset_throws", int'(throws), 0);
    chk("lit_reset_win", int'(win), 0);

    // natural 3+4
    pick(3); pick(4);
    chk("lit_sum7", int'(sum), 7);
    chk("lit_throws1", int'(throws), 1);
    @(negedge clk);
    chk("lit_win7", int'(win), 1);
    chk("lit_point0", int'(point), 0);
    chk("lit_roll_en_off", int'(roll_en), 0);

    // choose still high across new_game: no capture until released
    pulse_new_game();
    chk("lit_ng_roll_en", int'(roll_en), 1);
    chk("lit_ng_sum", int'(sum), 0);
    num = 3'd5;
    repeat (5) @(negedge clk);
    chk("lit_stale_choose", int'(die_a), 0);

    // craps 1+1
    pick(1); pick(1);
    @(negedge clk);
    chk("lit_lose2", int'(lose), 1);
    pulse_new_game();
    chk("lit_ng2_lose", int'(lose), 0);
    chk("lit_ng2_die_b", int'(die_b), 0);

    // point 4, continue, then make point
    pick(2); pick(2);
    @(negedge clk);
    chk("lit_point4", int'(point), 4);
    pick(5); pick(1);
    @(negedge clk);
    chk("lit_throws2", int'(throws), 2);
    chk("lit_continue_win", int'(win), 0);
    pick(3); pick(1);
    @(negedge clk);
    chk("lit_made_point", int'(win), 1);
    chk("lit_throws3", int'(throws), 3);
    pulse_new_game();

    // point 6 then seven-out
    pick(3); pick(3);
    @(negedge clk);
    chk("lit_point6", int'(point), 6);
    pick(4); pick(3);
    @(negedge clk);
    chk("lit_seven_out", int'(lose), 1);
    chk("lit_point_kept", int'(point), 6);
    pulse_new_game();

    // one release, choose held 50 cycles: single capture
    pick(2);
    num = 3'd6;
    repeat (50) @(negedge clk);
    chk("lit_held_die_a", int'(die_a), 2);
    chk("lit_held_throws", int'(throws), 0);

    // reset after first die only
    pulse_rst();
    pick(5);
    chk("lit_die_a5", int'(die_a), 5);
    pulse_rst();
    chk("lit_rst_die_a", int'(die_a), 0);

    // invalid face ignored
    num = 3'd0; choose = 1'b0;
    @(negedge clk);
    choose = 1'b1;
    @(negedge clk);
    chk("lit_face0", int'(die_a), 0);
    pick(4); pick(6);
    chk("lit_after_bad_sum", int'(sum), 10);
    chk("lit_after_bad_throws", int'(throws), 1);

    // randomized play
    for (int i = 0; i < 6000; i++) begin
      if ($urandom_range(0, 2) == 0) choose = ~choose;
      num = 3'($urandom_range(0, 7));
      new_game = ($urandom_range(0, 7) == 0);
      rst = ($urandom_range(0, 599) == 0);
      @(negedge clk);
    end
    rst = 1'b0; new_game = 1'b0;
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
